// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM state encoding,
// clock mode constants and the default word length.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int CPOL_LOW      = 0;
  localparam int CPOL_HIGH     = 1;
  localparam int CPHA_LEADING  = 0;
  localparam int CPHA_TRAILING = 1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises sclk, cs_n and mosi into clk and turns sclk/cs_n transitions
// into single-cycle sample/shift and select fall/rise pulses.
module spi_sync_edge #(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic mosi_s,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_n_fall,
  output logic cs_n_rise
);

  localparam logic IDLE_LVL     = 1'(CPOL);
  localparam bit   SAMPLE_TRAIL = (CPHA != 0);

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_prev_q, cs_prev_q;
  logic mosi_s_q, sample_q, shift_q, fall_q, rise_q;
  logic sclk_s, cs_s, sclk_chg, lead, trail;

  assign sclk_s   = sclk_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign sclk_chg = sclk_s != sclk_prev_q;
  assign lead     = sclk_chg && (sclk_s != IDLE_LVL);
  assign trail    = sclk_chg && (sclk_s == IDLE_LVL);

  // Edge pulses are registered together with mosi so both line up in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q      <= {SYNC_STAGES{IDLE_LVL}};
      cs_q        <= {SYNC_STAGES{1'b1}};
      mosi_q      <= '0;
      sclk_prev_q <= IDLE_LVL;
      cs_prev_q   <= 1'b1;
      mosi_s_q    <= 1'b0;
      sample_q    <= 1'b0;
      shift_q     <= 1'b0;
      fall_q      <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      mosi_s_q    <= mosi_q[SYNC_STAGES-1];
      sample_q    <= SAMPLE_TRAIL ? trail : lead;
      shift_q     <= SAMPLE_TRAIL ? lead : trail;
      fall_q      <= cs_prev_q & ~cs_s;
      rise_q      <= ~cs_prev_q & cs_s;
    end
  end

  assign mosi_s      = mosi_s_q;
  assign sample_edge = sample_q;
  assign shift_edge  = shift_q;
  assign cs_n_fall   = fall_q;
  assign cs_n_rise   = rise_q;

endmodule

// File: rtl/spi_responder.sv
// SPI responder: oversampled pins, MSB-first WIDTH-bit exchange with a tx holding
// register and rx valid pulse. SPI_RESPONDER_LOOPBACK_EN echoes last rx word on underrun.
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int CPOL        = CPOL_LOW,
  parameter int CPHA        = CPHA_LEADING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = $clog2(WIDTH + 1);

  logic mosi_s, sample_edge, shift_edge, cs_n_fall, cs_n_rise;

  spi_sync_edge #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .mosi_s      (mosi_s),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge),
    .cs_n_fall   (cs_n_fall),
    .cs_n_rise   (cs_n_rise)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d, fill_word, load_word, rx_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d, miso_q, miso_d, load;

`ifdef SPI_RESPONDER_LOOPBACK_EN
  assign fill_word = rx_data_q;
`else
  assign fill_word = '0;
`endif

  assign load_word = hold_full_q ? hold_q : fill_word;
  assign rx_next   = {rx_sh_q[WIDTH-2:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_n_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        rx_sh_d = '0;
        if (!cs_n_rise) begin
          load = 1'b1;
          // Leading-edge sampling needs the MSB on the wire before the first edge
          if (CPHA == CPHA_LEADING) begin
            miso_d  = load_word[WIDTH-1];
            tx_sh_d = load_word << 1;
          end else begin
            miso_d  = 1'b0;
            tx_sh_d = load_word;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_edge) begin
          miso_d  = tx_sh_q[WIDTH-1];
          tx_sh_d = tx_sh_q << 1;
        end
        if (sample_edge) begin
          rx_sh_d = rx_next;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            // Reloaded word is driven from the next shift edge onward
            if (!cs_n_rise) begin
              load    = 1'b1;
              tx_sh_d = load_word;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_n_rise) state_d = ST_IDLE;

    underrun_d = load && !hold_full_q;

    // A new word arriving in the copy cycle survives; the copy used the old contents
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 instance and a mode-3 instance
// driven by a behavioural SPI initiator with hand-computed expectations.
module tb_spi_responder;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
  logic       miso0, oe0, txr0, rxv0, busy0, ur0;
  logic [7:0] txd0 = '0, rxd0;
  logic       txv0 = 1'b0;

  logic       sclk3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;
  logic       miso3, oe3, txr3, rxv3, busy3, ur3;
  logic [7:0] txd3 = '0, rxd3;
  logic       txv3 = 1'b0;

  spi_responder u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0),
    .miso(miso0), .miso_oe(oe0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
    .underrun(ur0)
  );

  spi_responder #(.CPOL(1), .CPHA(1)) u_dut3 (
    .clk(clk), .rst(rst), .sclk(sclk3), .cs_n(cs3), .mosi(mosi3),
    .miso(miso3), .miso_oe(oe3), .tx_data(txd3), .tx_valid(txv3),
    .tx_ready(txr3), .rx_data(rxd3), .rx_valid(rxv3), .busy(busy3),
    .underrun(ur3)
  );

  int nchk = 0;
  int nerr = 0;
  int rxn0 = 0, urn0 = 0, rxn3 = 0;
  logic [7:0] rxlog0 [0:63];

  always @(negedge clk) begin
    if (rxv0) begin
      rxlog0[rxn0[5:0]] = rxd0;
      rxn0++;
    end
    if (ur0) urn0++;
    if (rxv3) rxn3++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_sclk(input bit m3, input logic v);
    if (m3) sclk3 = v; else sclk0 = v;
  endtask

  task automatic drv_cs(input bit m3, input logic v);
    if (m3) cs3 = v; else cs0 = v;
  endtask

  task automatic drv_mosi(input bit m3, input logic v);
    if (m3) mosi3 = v; else mosi0 = v;
  endtask

  task automatic push(input bit m3, input logic [7:0] d);
    @(negedge clk);
    if (m3) begin txd3 = d; txv3 = 1'b1; end
    else    begin txd0 = d; txv0 = 1'b1; end
    @(posedge clk);
    #1;
    txv0 = 1'b0;
    txv3 = 1'b0;
  endtask

  task automatic cs_low(input bit m3);
    drv_cs(m3, 1'b0);
    wait_clk(HALF);
  endtask

  task automatic cs_high(input bit m3);
    wait_clk(HALF);
    drv_cs(m3, 1'b1);
    wait_clk(2 * HALF);
  endtask

  // Initiator: m3=0 is CPOL0/CPHA0, m3=1 is CPOL1/CPHA1; miso read just before the sampling edge
  task automatic spi_bits(input bit m3, input logic [7:0] mo_in, input int nbits,
                          output logic [7:0] mi);
    logic [7:0] mo;
    mo = mo_in;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m3) begin
        drv_mosi(1'b0, mo[7]);
        wait_clk(HALF);
        mi = {mi[6:0], miso0};
        drv_sclk(1'b0, 1'b1);
        wait_clk(HALF);
        drv_sclk(1'b0, 1'b0);
      end else begin
        drv_sclk(1'b1, 1'b0);
        drv_mosi(1'b1, mo[7]);
        wait_clk(HALF);
        mi = {mi[6:0], miso3};
        drv_sclk(1'b1, 1'b1);
        wait_clk(HALF);
      end
      mo = mo << 1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a1, a2, w1, w2, exp3;
    int rx_s, ur_s;

    // Reset state
    wait_clk(3);
    check("rst_tx_ready", txr0, 1);
    check("rst_miso_oe", oe0, 0);
    check("rst_busy", busy0, 0);
    check("rst_rx_data", rxd0, 0);
    check("rst_rx_valid", rxv0, 0);
    check("rst_underrun", ur0, 0);
    check("rst_miso", miso0, 0);
    rst = 1'b1;
    wait_clk(4);

    // Test 1: mode 0 single word
    push(1'b0, 8'hA5);
    check("t1_tx_ready_drop", txr0, 0);
    rx_s = rxn0;
    cs_low(1'b0);
    check("t1_busy", busy0, 1);
    check("t1_miso_oe", oe0, 1);
    check("t1_tx_ready_after_load", txr0, 1);
    check("t1_miso_msb", miso0, 1);
    spi_bits(1'b0, 8'h3C, 8, w1);
    cs_high(1'b0);
    check("t1_miso_word", w1, 8'hA5);
    check("t1_rx_pulses", rxn0 - rx_s, 1);
    check("t1_rx_data", rxd0, 8'h3C);
    check("t1_oe_idle", oe0, 0);

    // Test 2: back-to-back words under one select
    push(1'b0, 8'h11);
    rx_s = rxn0;
    ur_s = urn0;
    cs_low(1'b0);
    spi_bits(1'b0, 8'hF0, 4, a1);
    push(1'b0, 8'h22);
    spi_bits(1'b0, 8'h00, 4, a2);
    push(1'b0, 8'h33);
    spi_bits(1'b0, 8'h0F, 8, w2);
    cs_high(1'b0);
    check("t2_miso_word1", {a1[3:0], a2[3:0]}, 8'h11);
    check("t2_miso_word2", w2, 8'h22);
    check("t2_rx_pulses", rxn0 - rx_s, 2);
    check("t2_rx_word1", rxlog0[rx_s[5:0]], 8'hF0);
    check("t2_rx_word2", rxlog0[rx_s[5:0] + 6'd1], 8'h0F);
    check("t2_no_underrun", urn0 - ur_s, 0);

    // Test 3: empty holding register at select
`ifdef SPI_RESPONDER_LOOPBACK_EN
    exp3 = 8'h0F;
`else
    exp3 = 8'h00;
`endif
    ur_s = urn0;
    cs_low(1'b0);
    check("t3_underrun_pulse", urn0 - ur_s, 1);
    spi_bits(1'b0, 8'h5A, 8, w1);
    cs_high(1'b0);
    check("t3_miso_word", w1, exp3);
    check("t3_rx_data", rxd0, 8'h5A);

    // Test 4: select released after 5 bits
    rx_s = rxn0;
    cs_low(1'b0);
    spi_bits(1'b0, 8'hE7, 5, w1);
    wait_clk(HALF);
    cs0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_oe_released", oe0, 0);
    wait_clk(2 * HALF);
    check("t4_no_rx_valid", rxn0 - rx_s, 0);
    check("t4_rx_data_kept", rxd0, 8'h5A);
    push(1'b0, 8'h69);
    cs_low(1'b0);
    spi_bits(1'b0, 8'hC5, 8, w1);
    cs_high(1'b0);
    check("t4_next_miso", w1, 8'h69);
    check("t4_next_rx", rxd0, 8'hC5);

    // Test 5: CPOL=1, CPHA=1
    push(1'b1, 8'hC3);
    rx_s = rxn3;
    cs_low(1'b1);
    check("t5_miso_before_first_edge", miso3, 0);
    spi_bits(1'b1, 8'h81, 8, w1);
    cs_high(1'b1);
    check("t5_miso_word", w1, 8'hC3);
    check("t5_rx_data", rxd3, 8'h81);
    check("t5_rx_pulses", rxn3 - rx_s, 1);

    // Test 6: reset mid-word
    push(1'b0, 8'h77);
    cs_low(1'b0);
    spi_bits(1'b0, 8'hAA, 3, w1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_tx_ready", txr0, 1);
    check("t6_miso_oe", oe0, 0);
    check("t6_busy", busy0, 0);
    check("t6_rx_data", rxd0, 0);
    check("t6_miso", miso0, 0);
    check("t6_rx_valid", rxv0, 0);
    check("t6_underrun", ur0, 0);
    cs0 = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    ur_s = urn0;
    cs_low(1'b0);
    check("t6_underrun_after_reset", urn0 - ur_s, 1);
    check("t6_busy_after_reset", busy0, 1);
    cs_high(1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
